// File: rtl/stopwatch_seconds_ctrl.sv
// Stopwatch seconds stage: idle/run/pause control, 1 Hz prescaler and 0..59 seconds
// counter feeding the minutes stage with enable and a same-cycle overflow strobe.
module stopwatch_seconds_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       enable,
  output logic       paused,
  output logic       sec_tick,
  output logic       sec_overflow,
  output logic [7:0] seconds,
  output logic       clr_pulse
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]         SEC_LAST   = 8'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t               state_r;
  logic [PRESC_W-1:0]   presc_r;
  logic [7:0]           seconds_r;
  logic                 clr_pulse_r;
  logic                 advance_s;
  logic                 tick_s;
  logic                 overflow_s;

  // Prescaler advance and tick qualification; a stop or clear in the same cycle wins.
  always_comb begin
    advance_s  = 1'b0;
    tick_s     = 1'b0;
    overflow_s = 1'b0;
    if ((state_r == RUN) && !stop && !clear) begin
      advance_s  = 1'b1;
      tick_s     = (presc_r == PRESC_LAST);
      overflow_s = (presc_r == PRESC_LAST) && (seconds_r == SEC_LAST);
    end else begin
      advance_s  = 1'b0;
      tick_s     = 1'b0;
      overflow_s = 1'b0;
    end
  end

  // Control FSM with clear > stop > start priority, plus the clear strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      clr_pulse_r <= 1'b0;
    end else begin
      clr_pulse_r <= clear;
      if (clear) begin
        state_r <= IDLE;
      end else begin
        case (state_r)
          IDLE:    state_r <= start ? RUN : IDLE;
          RUN:     state_r <= stop ? PAUSE : RUN;
          PAUSE:   state_r <= start ? RUN : PAUSE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Prescaler and seconds counter; pause simply withholds advance so the phase survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r   <= '0;
      seconds_r <= 8'd0;
    end else if (clear) begin
      presc_r   <= '0;
      seconds_r <= 8'd0;
    end else if (advance_s) begin
      if (presc_r == PRESC_LAST) begin
        presc_r   <= '0;
        seconds_r <= (seconds_r == SEC_LAST) ? 8'd0 : seconds_r + 8'd1;
      end else begin
        presc_r   <= presc_r + PRESC_W'(1);
      end
    end
  end

  assign enable       = (state_r == RUN);
  assign paused       = (state_r == PAUSE);
  assign sec_tick     = tick_s;
  assign sec_overflow = overflow_s;
  assign seconds      = seconds_r;
  assign clr_pulse    = clr_pulse_r;

endmodule

// File: tb/tb_stopwatch_seconds_ctrl.sv
// Bench for stopwatch_seconds_ctrl: elapsed-running-time model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_stopwatch_seconds_ctrl;

  localparam int TPS = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clear = 1'b0;
  logic       enable, paused, sec_tick, sec_overflow, clr_pulse;
  logic [7:0] seconds;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: mode 0 idle, 1 running, 2 paused; m_total counts running cycles since clear.
  int m_mode  = 0;
  int m_total = 0;
  int m_clr   = 0;
  int minutes_dut = 0;

  always #5 clk = ~clk;

  stopwatch_seconds_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .enable(enable), .paused(paused), .sec_tick(sec_tick),
    .sec_overflow(sec_overflow), .seconds(seconds), .clr_pulse(clr_pulse)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit exp_tick();
    return (m_mode == 1) && !stop && !clear && ((m_total % TPS) == TPS - 1);
  endfunction

  // Reference model update on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_total <= 0;
      m_clr   <= 0;
    end else if (clear) begin
      m_mode  <= 0;
      m_total <= 0;
      m_clr   <= 1;
    end else begin
      m_clr <= 0;
      if (m_mode == 1 && !stop) m_total <= m_total + 1;
      if (m_mode == 1 && stop) m_mode <= 2;
      else if (m_mode != 1 && start) m_mode <= 1;
    end
  end

  // Downstream minutes stage driven by the DUT outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) minutes_dut <= 0;
    else if (clear) minutes_dut <= 0;
    else if (enable && sec_overflow) minutes_dut <= minutes_dut + 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("enable", enable, m_mode == 1);
      chk("paused", paused, m_mode == 2);
      chk("seconds", seconds, (m_total / TPS) % 60);
      chk("sec_tick", sec_tick, exp_tick());
      chk("sec_overflow", sec_overflow, exp_tick() && (((m_total + 1) % (TPS * 60)) == 0));
      chk("clr_pulse", clr_pulse, m_clr);
      chk("minutes", minutes_dut, m_total / (TPS * 60));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    check_en = 1'b1;
    step();
    chk("rst_enable", enable, 1'b0);
    chk("rst_seconds", seconds, 8'd0);
    chk("rst_clr_pulse", clr_pulse, 1'b0);

    // Basic run: ticks on running cycles 4, 8, 12
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      #1;
      chk("run_tick", sec_tick, (i % 4) == 0);
      chk("run_enable", enable, 1'b1);
      step();
    end
    chk("run_seconds", seconds, 8'd3);

    // Asynchronous reset mid-run at seconds = 12
    repeat (36) step();
    chk("pre_rst_seconds", seconds, 8'd12);
    chk("pre_rst_enable", enable, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_seconds", seconds, 8'd0);
    chk("async_rst_enable", enable, 1'b0);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_enable", enable, 1'b0);
      chk("post_rst_seconds", seconds, 8'd0);
      chk("post_rst_tick", sec_tick, 1'b0);
      step();
    end

    // Wrap 59 -> 0 with same-cycle overflow and enable
    pulse_start();
    n = 0;
    while (seconds != 8'd59 && n < 300) begin
      step();
      n++;
    end
    chk("reach_59", seconds == 8'd59, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_overflow", sec_overflow, i == 3);
      chk("wrap_enable", enable, 1'b1);
      step();
    end
    chk("wrap_seconds", seconds, 8'd0);
    chk("wrap_minutes", minutes_dut, 1);

    // Clear from RUN, then pause mid-second at prescaler 2, seconds 5
    pulse_clear();
    chk("clr_run_pulse", clr_pulse, 1'b1);
    chk("clr_run_enable", enable, 1'b0);
    chk("clr_run_minutes", minutes_dut, 0);
    step();
    chk("clr_run_pulse_fall", clr_pulse, 1'b0);
    pulse_start();
    repeat (22) step();
    chk("pause_pre_seconds", seconds, 8'd5);
    pulse_stop();
    chk("pause_paused", paused, 1'b1);
    repeat (20) step();
    chk("pause_hold_paused", paused, 1'b1);
    chk("pause_hold_seconds", seconds, 8'd5);
    pulse_start();
    #1 chk("resume_tick_a", sec_tick, 1'b0);
    step();
    #1 chk("resume_tick_b", sec_tick, 1'b1);
    step();
    chk("resume_seconds", seconds, 8'd6);
    chk("resume_enable", enable, 1'b1);

    // Stop on the terminal cycle suppresses the tick until resume
    repeat (3) step();
    stop = 1'b1;
    #1 chk("term_stop_tick", sec_tick, 1'b0);
    step();
    stop = 1'b0;
    chk("term_paused", paused, 1'b1);
    chk("term_seconds", seconds, 8'd6);
    pulse_start();
    #1 chk("term_resume_tick", sec_tick, 1'b1);
    step();
    chk("term_resume_seconds", seconds, 8'd7);

    // Clear while paused at seconds = 37
    repeat (120) step();
    chk("pre37_seconds", seconds, 8'd37);
    pulse_stop();
    chk("p37_paused", paused, 1'b1);
    chk("p37_seconds", seconds, 8'd37);
    pulse_clear();
    chk("clr_p_paused", paused, 1'b0);
    chk("clr_p_enable", enable, 1'b0);
    chk("clr_p_seconds", seconds, 8'd0);
    chk("clr_p_pulse", clr_pulse, 1'b1);
    step();
    chk("clr_p_pulse_fall", clr_pulse, 1'b0);

    // All three pulses together on the terminal cycle in RUN
    pulse_start();
    repeat (3) step();
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    #1 chk("all_tick", sec_tick, 1'b0);
    step();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    chk("all_enable", enable, 1'b0);
    chk("all_paused", paused, 1'b0);
    chk("all_seconds", seconds, 8'd0);
    chk("all_pulse", clr_pulse, 1'b1);

    // Ignored inputs: stop in IDLE, start in RUN
    pulse_stop();
    chk("idle_stop_enable", enable, 1'b0);
    chk("idle_stop_paused", paused, 1'b0);
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      start = (i == 2);
      #1 chk("ign_tick", sec_tick, (i % 4) == 0);
      step();
    end
    start = 1'b0;
    chk("ign_seconds", seconds, 8'd2);
    chk("ign_enable", enable, 1'b1);

    repeat (3) step();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_seconds_ctrl.md
Name: stopwatch_seconds_ctrl

Overview:
Stopwatch front-end stage that sits directly upstream of the minutes counter. It holds the run/pause/idle control FSM, divides clk down to a 1 Hz tick with a prescaler, and counts seconds 0–59. It drives the `enable` and `sec_overflow` inputs of the minutes stage, plus a one-cycle clear strobe that top level uses to zero the minutes stage.

Parameters:
- TICKS_PER_SEC, default 100_000_000: clk cycles per second. Must be >= 2. The bench uses 4.
- PRESC_W, default $clog2(TICKS_PER_SEC): prescaler width. Derived; do not override.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse, already synchronised and debounced; run or resume.
- stop, input, 1: one-cycle pulse; pause.
- clear, input, 1: one-cycle pulse; return to idle and zero all counts.
- enable, output, 1: high while in RUN. Connects to the minutes stage `enable`.
- paused, output, 1: high while in PAUSE.
- sec_tick, output, 1: one-cycle pulse on every seconds increment.
- sec_overflow, output, 1: one-cycle pulse when seconds wraps 59->0. Connects to the minutes stage.
- seconds, output, 8: current seconds, 0..59, binary.
- clr_pulse, output, 1: registered one-cycle strobe after any accepted clear.

Behaviour:
- Reset (rst_n low, asynchronous, no clock edge needed):
  - state = IDLE; prescaler = 0; seconds = 0; clr_pulse = 0.
  - enable, paused, sec_tick and sec_overflow are therefore 0.
  - Reset mid-run discards the prescaler phase.
- FSM states: IDLE, RUN, PAUSE.
- Input priority when pulses coincide: clear > stop > start.
- IDLE:
  - start -> RUN.
  - clear -> IDLE and clr_pulse fires.
  - stop is ignored.
- RUN:
  - clear -> IDLE.
  - stop -> PAUSE.
  - start is ignored.
- PAUSE:
  - clear -> IDLE.
  - start -> RUN.
  - stop is ignored.
- Decoded outputs: enable = (state == RUN); paused = (state == PAUSE). Both are pure decodes of registered state.
- Prescaler:
  - Advances only in cycles where state == RUN and neither stop nor clear is asserted.
  - Counts 0..TICKS_PER_SEC-1, then wraps to 0.
  - In PAUSE it holds its value, so the sub-second phase is preserved across pause and resume.
- sec_tick (combinational) = (state == RUN) & (prescaler == TICKS_PER_SEC-1) & !stop & !clear.
  - A stop on the terminal cycle suppresses the tick and leaves the prescaler at its terminal value.
  - After resume, the first RUN cycle then produces the tick.
- seconds:
  - On a sec_tick edge: 59 -> 0, otherwise +1.
  - Never holds a value above 59.
- sec_overflow (combinational) = sec_tick & (seconds == 59).
  - It is asserted in the same cycle as enable = 1.
  - The minutes stage therefore increments on the same edge that seconds wraps to 0, giving a coherent mm:ss display with no one-cycle skew.
- Clear (any state):
  - Next edge: state = IDLE, prescaler = 0, seconds = 0, clr_pulse = 1.
  - clr_pulse falls one cycle later unless clear is re-asserted.
- Latency from input pulse to state change: 1 clk. enable falls in the cycle after stop or clear is sampled.
- Arithmetic: all counters unsigned, compare-and-wrap. No reliance on natural modulo wrap.

Test Plan (TICKS_PER_SEC = 4):
1. Reset:
   - Stimulus: reach RUN with seconds = 12, then drive rst_n low between clock edges.
   - Response: seconds = 0 and enable = 0 immediately, before the next edge.
   - After release, with no start applied: outputs stay 0 for 10 cycles.
2. Basic run:
   - Stimulus: start, then run 12 cycles.
   - Response: sec_tick high exactly on running cycles 4, 8 and 12; seconds steps 1, 2, 3.
   - enable = 1 from the cycle after start.
3. Wrap:
   - Stimulus: run until seconds = 59, then 4 more cycles.
   - Response: sec_overflow and enable both high for exactly one cycle; seconds becomes 0 on that edge.
   - A modelled minutes stage reads 1.
4. Pause mid-second:
   - Stimulus: stop when prescaler = 2 and seconds = 5, wait 20 cycles, then start.
   - Response: paused = 1 and seconds holds 5 while paused; after start, tick occurs after 2 running cycles and seconds = 6.
   - Variant: stop on the terminal cycle gives no tick, and the tick appears on the first cycle after resume.
5. Clear while paused:
   - Stimulus: clear in PAUSE with seconds = 37.
   - Response: next cycle state = IDLE, seconds = 0, clr_pulse = 1 for one cycle.
   - Variant: start, stop and clear together in RUN -> IDLE, with no tick that cycle.
6. Ignored inputs:
   - Stimulus: stop in IDLE; start in RUN.
   - Response: no state change, no prescaler disturbance, tick cadence unchanged.
